// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit payload for the binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BIN_W   = 14;             // binary operand width
  localparam int unsigned NDIG    = 4;              // BCD digits produced
  localparam int unsigned MAX_VAL = 9999;           // largest representable value
  localparam int unsigned BCD_W   = 4 * NDIG;       // packed BCD field width
  localparam int unsigned SR_W    = BCD_W + BIN_W;  // double-dabble shift register
  localparam int unsigned CNT_W   = 4;              // holds 0..BIN_W-1

  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Four BCD digits, most significant first in the packed vector.
  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd4_t;

endpackage

// File: rtl/bin_to_bcd4_if.sv
// Start/busy/valid handshake plus operand and digit results of the converter.
//   master : drives start/bin, observes busy/valid/ovf/digits
//   slave  : the converter side
interface bin_to_bcd4_if;
  import bcd_pkg::*;

  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             valid;
  logic             ovf;
  logic [3:0]       digit0;
  logic [3:0]       digit1;
  logic [3:0]       digit2;
  logic [3:0]       digit3;

  modport master (
    output start, bin,
    input  busy, valid, ovf, digit0, digit1, digit2, digit3
  );

  modport slave (
    input  start, bin,
    output busy, valid, ovf, digit0, digit1, digit2, digit3
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more.
//   din  : nibble before correction
//   dout : corrected nibble
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd4.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3, one bit per clock).
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : slave side of bin_to_bcd4_if
//           start/bin in; busy, valid (1-cycle pulse), ovf and digit0..digit3 out.
//           Inputs above MAX_VAL saturate to 9999 with ovf set.
module bin_to_bcd4
  import bcd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  bin_to_bcd4_if.slave  bus
);

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              ovf_lat_q, ovf_lat_d;
  logic              ovf_q, ovf_d;
  bcd4_t             digits_q, digits_d;

  logic [BCD_W-1:0]  bcd_corr;
  logic [SR_W-1:0]   sr_shift;

  // Per-digit add-3 correction on the BCD field of the shift register.
  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (sr_q[BIN_W + 4*g +: 4]),
      .dout (bcd_corr[4*g +: 4])
    );
  end

  // Corrected register shifted left by one; the bit leaving the top is dropped.
  assign sr_shift = {bcd_corr[BCD_W-2:0], sr_q[BIN_W-1:0], 1'b0};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovf_lat_q <= 1'b0;
      ovf_q     <= 1'b0;
      digits_q  <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ovf_lat_q <= ovf_lat_d;
      ovf_q     <= ovf_d;
      digits_q  <= digits_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    ovf_lat_d = ovf_lat_q;
    ovf_d     = ovf_q;
    digits_d  = digits_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d      = {BCD_W'(0), bus.bin};
          ovf_lat_d = (bus.bin > BIN_W'(MAX_VAL));
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        // Last of the BIN_W shifts: publish result, saturating when out of range.
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          digits_d = ovf_lat_q ? bcd4_t'({NDIG{BCD_NINE}})
                               : bcd4_t'(sr_shift[SR_W-1 -: BCD_W]);
          ovf_d    = ovf_lat_q;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.ovf    = ovf_q;
  assign bus.digit0 = digits_q.d0;
  assign bus.digit1 = digits_q.d1;
  assign bus.digit2 = digits_q.d2;
  assign bus.digit3 = digits_q.d3;

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Self-checking bench for bin_to_bcd4: scoreboard of expected digits/ovf/latency.
module tb_bin_to_bcd4;
  import bcd_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bin_to_bcd4_if bus ();

  bin_to_bcd4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] dig;
    logic        ovf;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_tests   = 0;
  int unsigned n_fail    = 0;
  int unsigned cyc       = 0;
  int unsigned valid_cnt = 0;
  int unsigned spurious  = 0;
  int unsigned vc_snap   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference conversion by decimal arithmetic.
  function automatic logic [15:0] model(input int unsigned v);
    if (v > MAX_VAL) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] digits_now();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction

  // Output monitor: every valid pulse pops and checks one expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.valid === 1'b1) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        spurious++;
      end else begin
        mon_e = sb.pop_front();
        chk("digits", 32'(digits_now()), 32'(mon_e.dig));
        chk("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
        chk("latency", 32'(cyc - mon_e.acc), 32'd14);
      end
    end
  end

  // Call at a negedge while idle; returns at the negedge after the accepting edge.
  task automatic start_conv(input int unsigned v);
    exp_t e;
    chk("idle_before_start", 32'(bus.busy), 32'd0);
    e.dig = model(v);
    e.ovf = (v > MAX_VAL);
    e.acc = cyc + 1;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.bin   = 14'(v);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  // Returns at the negedge where valid is high (or after the budget expires).
  task automatic wait_valid(input int unsigned budget);
    int unsigned n = 0;
    while (bus.valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", 32'(bus.valid), 32'd1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"},   32'(bus.busy),     32'd0);
    chk({tag, "_valid"},  32'(bus.valid),    32'd0);
    chk({tag, "_ovf"},    32'(bus.ovf),      32'd0);
    chk({tag, "_digits"}, 32'(digits_now()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;

    // Zero input.
    @(negedge clk);
    start_conv(0);
    wait_valid(20);

    // Plain in-range value.
    @(negedge clk);
    start_conv(4353);
    wait_valid(20);

    // Max value, then back-to-back start in the valid cycle.
    @(negedge clk);
    start_conv(9999);
    wait_valid(20);
    start_conv(363);
    wait_valid(20);

    // Saturation, then recovery.
    @(negedge clk);
    start_conv(12000);
    wait_valid(20);
    @(negedge clk);
    start_conv(3578);
    wait_valid(20);

    // Out-of-range boundary just above and at the top of the binary range.
    @(negedge clk);
    start_conv(10000);
    wait_valid(20);
    @(negedge clk);
    start_conv(16383);
    wait_valid(20);
    @(negedge clk);
    start_conv(1009);
    wait_valid(20);

    // Start while busy is ignored; bin change while busy has no effect.
    @(negedge clk);
    vc_snap = valid_cnt;
    start_conv(3542);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 14'd1111;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(20);
    repeat (20) @(negedge clk);
    chk("single_valid", 32'(valid_cnt - vc_snap), 32'd1);
    chk("hold_digits", 32'(digits_now()), 32'h3542);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Reset mid-conversion abandons it.
    @(negedge clk);
    start_conv(1234);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    vc_snap = valid_cnt;
    chk_cleared("midrst");
    repeat (20) @(negedge clk);
    chk("no_valid_after_rst", 32'(valid_cnt - vc_snap), 32'd0);
    chk("spurious_valid", 32'(spurious), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
